lsu_master: RTL and testbench

LSU_MASTER -- requirements
Module: lsu_master

---
 rtl/lsu_master.sv | 145 ++++++++++++++
 tb/tb_lsu_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_master.sv
// Load/store unit bus master: turns core load/store commands into single
// word-aligned bus transactions with lane masking, load formatting and timeout.
module lsu_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [1:0]  cmd_size_i,
  input  logic        cmd_unsigned_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        res_valid_o,
  output logic [31:0] res_rdata_o,
  output logic        res_err_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  input  logic        rsp_valid_i,
  output logic        rsp_ready_o,
  input  logic [31:0] data_i
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t      state, state_next;
  logic [31:0] wait_cnt;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        unsigned_q;

  logic        accept, misaligned, req_fire, rsp_fire, abort;
  logic [3:0]  sel_next;
  logic [31:0] data_next, lane_data, load_data;

  assign cmd_ready_o = (state == IDLE) && !rst;
  assign req_valid_o = (state == REQ);
  assign rsp_ready_o = (state == RSP);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign req_fire    = req_valid_o && req_ready_i;
  assign rsp_fire    = rsp_ready_o && rsp_valid_i;

  // A handshake in the final allowed cycle wins over the timeout.
  assign abort = (TIMEOUT_CYCLES != 0) && (state != IDLE) && !req_fire && !rsp_fire &&
                 (wait_cnt >= TIMEOUT_CYCLES - 1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    misaligned = 1'b0;
    sel_next   = 4'b0000;
    data_next  = 32'h0;
    case (cmd_size_i)
      2'b00: begin
        sel_next  = 4'b0001 << cmd_addr_i[1:0];
        data_next = {4{cmd_wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned = cmd_addr_i[0];
        sel_next   = 4'b0011 << cmd_addr_i[1:0];
        data_next  = {2{cmd_wdata_i[15:0]}};
      end
      2'b10: begin
        misaligned = |cmd_addr_i[1:0];
        sel_next   = 4'b1111;
        data_next  = cmd_wdata_i;
      end
      default: misaligned = 1'b1;
    endcase
    if (!cmd_we_i) data_next = 32'h0;
  end

  always_comb begin
    lane_data = data_i >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_data = {{24{lane_data[7] & ~unsigned_q}}, lane_data[7:0]};
      2'b01:   load_data = {{16{lane_data[15] & ~unsigned_q}}, lane_data[15:0]};
      default: load_data = lane_data;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !misaligned) state_next = REQ;
      REQ:     if (req_fire) state_next = RSP;
               else if (abort) state_next = IDLE;
      RSP:     if (rsp_fire || abort) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 32'h0;
      addr_o      <= 32'h0;
      data_o      <= 32'h0;
      sel_o       <= 4'h0;
      we_o        <= 1'b0;
      lane_q      <= 2'b00;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      res_valid_o <= 1'b0;
      res_err_o   <= 1'b0;
      res_rdata_o <= 32'h0;
    end else begin
      state       <= state_next;
      res_valid_o <= 1'b0;
      res_err_o   <= 1'b0;
      res_rdata_o <= 32'h0;
      if (accept) begin
        if (misaligned) begin
          res_valid_o <= 1'b1;
          res_err_o   <= 1'b1;
        end else begin
          addr_o     <= {cmd_addr_i[31:2], 2'b00};
          data_o     <= data_next;
          sel_o      <= sel_next;
          we_o       <= cmd_we_i;
          lane_q     <= cmd_addr_i[1:0];
          size_q     <= cmd_size_i;
          unsigned_q <= cmd_unsigned_i;
          wait_cnt   <= 32'h0;
        end
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + 32'h1;
      end
      if (rsp_fire) begin
        res_valid_o <= 1'b1;
        res_rdata_o <= we_o ? 32'h0 : load_data;
      end else if (abort) begin
        res_valid_o <= 1'b1;
        res_err_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// Self-checking bench for lsu_master: directed scenarios with literal
// expectations plus randomized traffic compared each cycle to a reference model.
module tb_lsu_master;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_unsigned_i;
  logic [1:0]  cmd_size_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        res_valid_o, res_err_o;
  logic [31:0] res_rdata_o;
  logic [31:0] addr_o, data_o;
  logic [3:0]  sel_o;
  logic        we_o, req_valid_o, req_ready_i, rsp_valid_i, rsp_ready_o;
  logic [31:0] data_i;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  lsu_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_size_i(cmd_size_i), .cmd_unsigned_i(cmd_unsigned_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .res_valid_o(res_valid_o), .res_rdata_o(res_rdata_o), .res_err_o(res_err_o),
    .addr_o(addr_o), .data_o(data_o), .sel_o(sel_o), .we_o(we_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .data_i(data_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction with an age in cycles.
  int          m_phase;   // 0 no transaction, 1 awaiting bus accept, 2 awaiting response
  int unsigned m_age;
  int          m_size, m_off;
  bit          m_uns;
  logic [31:0] m_addr, m_data, m_rdata, lane, v;
  logic [3:0]  m_sel;
  logic        m_we, m_res_valid, m_res_err;

  initial begin
    m_phase = 0; m_age = 0; m_size = 0; m_off = 0; m_uns = 0;
    m_addr = 0; m_data = 0; m_sel = 0; m_we = 0;
    m_res_valid = 0; m_res_err = 0; m_rdata = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_age = 0; m_addr = 0; m_data = 0; m_sel = 0; m_we = 0;
      m_res_valid = 0; m_res_err = 0; m_rdata = 0;
    end else begin
      m_res_valid = 0; m_res_err = 0; m_rdata = 0;
      if (m_phase == 0) begin
        if (cmd_valid_i) begin
          if (cmd_size_i == 3 || (cmd_size_i == 1 && cmd_addr_i % 2 != 0) ||
              (cmd_size_i == 2 && cmd_addr_i % 4 != 0)) begin
            m_res_valid = 1; m_res_err = 1;
          end else begin
            m_size = int'(cmd_size_i);
            m_off  = int'(cmd_addr_i % 4);
            m_uns  = cmd_unsigned_i;
            m_we   = cmd_we_i;
            m_addr = cmd_addr_i - (cmd_addr_i % 4);
            if (m_size == 0) begin
              m_sel = 4'(1 << m_off); m_data = (cmd_wdata_i & 32'hFF) * 32'h01010101;
            end else if (m_size == 1) begin
              m_sel = 4'(3 << m_off); m_data = (cmd_wdata_i & 32'hFFFF) * 32'h00010001;
            end else begin
              m_sel = 4'hF; m_data = cmd_wdata_i;
            end
            if (!cmd_we_i) m_data = 0;
            m_phase = 1; m_age = 0;
          end
        end
      end else begin
        if ((m_phase == 1 && req_ready_i) || (m_phase == 2 && rsp_valid_i)) begin
          if (m_phase == 2) begin
            lane = data_i >> (8 * m_off);
            if (m_size == 0) begin
              v = lane & 32'hFF;
              if (!m_uns && v >= 128) v = v | 32'hFFFFFF00;
            end else if (m_size == 1) begin
              v = lane & 32'hFFFF;
              if (!m_uns && v >= 32768) v = v | 32'hFFFF0000;
            end else v = lane;
            m_res_valid = 1;
            m_rdata = m_we ? 32'h0 : v;
            m_phase = 0;
          end else m_phase = 2;
          m_age++;
        end else if (TO != 0 && m_age + 1 >= TO) begin
          m_res_valid = 1; m_res_err = 1; m_phase = 0;
        end else m_age++;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("cmd_ready", 32'(cmd_ready_o), 32'(m_phase == 0 && !rst));
      check("req_valid", 32'(req_valid_o), 32'(m_phase == 1));
      check("rsp_ready", 32'(rsp_ready_o), 32'(m_phase == 2));
      check("res_valid", 32'(res_valid_o), 32'(m_res_valid));
      check("res_err",   32'(res_err_o),   32'(m_res_err));
      check("res_rdata", res_rdata_o, m_rdata);
      check("addr_o",    addr_o, m_addr);
      check("data_o",    data_o, m_data);
      check("sel_o",     32'(sel_o), 32'(m_sel));
      check("we_o",      32'(we_o), 32'(m_we));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_size_i = size;
    cmd_unsigned_i = uns; cmd_addr_i = addr; cmd_wdata_i = wdata;
  endtask

  initial begin
    int r;
    rst = 1'b1; cmd_valid_i = 0; cmd_we_i = 0; cmd_size_i = 0; cmd_unsigned_i = 0;
    cmd_addr_i = 0; cmd_wdata_i = 0; req_ready_i = 0; rsp_valid_i = 0; data_i = 0;
    tick;
    mon_en = 1'b1;
    tick;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'h0);
    check("rst_req_valid", 32'(req_valid_o), 32'h0);
    check("rst_res_valid", 32'(res_valid_o), 32'h0);
    tick;
    rst = 1'b0;
    req_ready_i = 1; rsp_valid_i = 1; data_i = 32'hDEADBEEF;

    // Word load, immediate bus handshakes.
    set_cmd(0, 2'b10, 0, 32'h100, 0);
    @(negedge clk); check("wl_ready", 32'(cmd_ready_o), 32'h1);
    tick; cmd_valid_i = 0;
    @(negedge clk);
    check("wl_req_valid", 32'(req_valid_o), 32'h1);
    check("wl_addr", addr_o, 32'h100);
    check("wl_sel", 32'(sel_o), 32'hF);
    tick; tick;
    // Signed byte load issued in the completion cycle of the previous one.
    data_i = 32'h80FFFFFF;
    set_cmd(0, 2'b00, 0, 32'h103, 0);
    @(negedge clk);
    check("wl_res_valid", 32'(res_valid_o), 32'h1);
    check("wl_rdata", res_rdata_o, 32'hDEADBEEF);
    check("wl_err", 32'(res_err_o), 32'h0);
    check("b2b_ready", 32'(cmd_ready_o), 32'h1);
    tick; cmd_valid_i = 0;
    @(negedge clk); check("sb_sel", 32'(sel_o), 32'h8);
    tick; tick;
    set_cmd(0, 2'b00, 1, 32'h103, 0);
    @(negedge clk); check("sb_rdata", res_rdata_o, 32'hFFFFFF80);
    tick; cmd_valid_i = 0;
    @(negedge clk); check("ub_sel", 32'(sel_o), 32'h8);
    tick; tick;
    set_cmd(1, 2'b01, 0, 32'h202, 32'h1234ABCD);
    @(negedge clk); check("ub_rdata", res_rdata_o, 32'h00000080);
    tick; cmd_valid_i = 0;
    @(negedge clk);
    check("hs_addr", addr_o, 32'h200);
    check("hs_sel", 32'(sel_o), 32'hC);
    check("hs_data", data_o, 32'hABCDABCD);
    check("hs_we", 32'(we_o), 32'h1);
    tick; tick;
    // Misaligned word load.
    set_cmd(0, 2'b10, 0, 32'h101, 0);
    @(negedge clk); check("hs_rdata", res_rdata_o, 32'h0);
    tick; cmd_valid_i = 0;
    @(negedge clk);
    check("mis_req_valid", 32'(req_valid_o), 32'h0);
    check("mis_res_valid", 32'(res_valid_o), 32'h1);
    check("mis_err", 32'(res_err_o), 32'h1);
    tick;
    @(negedge clk); check("mis_req_valid2", 32'(req_valid_o), 32'h0);

    // Timeout with the bus never accepting.
    req_ready_i = 0;
    set_cmd(0, 2'b10, 0, 32'h100, 0);
    tick; cmd_valid_i = 0;
    for (int k = 0; k < int'(TO); k++) begin
      @(negedge clk); check("to_req_valid", 32'(req_valid_o), 32'h1);
      tick;
    end
    @(negedge clk);
    check("to_req_low", 32'(req_valid_o), 32'h0);
    check("to_res_valid", 32'(res_valid_o), 32'h1);
    check("to_err", 32'(res_err_o), 32'h1);
    check("to_rdata", res_rdata_o, 32'h0);
    check("to_idle", 32'(cmd_ready_o), 32'h1);
    tick;

    // Reset while a request is pending.
    set_cmd(0, 2'b10, 0, 32'h300, 0);
    tick; cmd_valid_i = 0;
    @(negedge clk); check("rr_req_valid", 32'(req_valid_o), 32'h1);
    tick; rst = 1'b1;
    tick;
    @(negedge clk);
    check("rr_req_low", 32'(req_valid_o), 32'h0);
    check("rr_res_valid", 32'(res_valid_o), 32'h0);
    check("rr_addr", addr_o, 32'h0);
    check("rr_sel", 32'(sel_o), 32'h0);
    tick; rst = 1'b0;
    tick;
    @(negedge clk); check("rr_no_pulse", 32'(res_valid_o), 32'h0);

    // Randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick;
      rst = ($urandom_range(0, 299) == 0);
      cmd_valid_i = $urandom_range(0, 1);
      cmd_we_i = $urandom_range(0, 1);
      cmd_unsigned_i = $urandom_range(0, 1);
      r = $urandom_range(0, 15);
      cmd_size_i = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
      cmd_addr_i = $urandom;
      if ($urandom_range(0, 1) == 1) cmd_addr_i[1:0] = 2'b00;
      cmd_wdata_i = $urandom;
      data_i = $urandom;
      req_ready_i = ($urandom_range(0, 9) < 7) && (cyc % 500 >= 40);
      rsp_valid_i = ($urandom_range(0, 9) < 7) && (cyc % 500 < 80 || cyc % 500 >= 120);
    end
    tick;
    rst = 1'b0; cmd_valid_i = 0;
    repeat (10) tick;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
